// File: rtl/bitfusion_feeder.sv
// Input-side sequencer for the BitFusion systolic array: accepts activation
// vectors, skews them diagonally across rows, and pulses per-column acc_clear.
module bitfusion_feeder #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         start,
  input  logic [LEN_W-1:0]             tile_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ARRAY_SIZE*DATA_W-1:0] in_data,
  output logic [ARRAY_SIZE*DATA_W-1:0] IBUF,
  output logic [ARRAY_SIZE-1:0]        input_rd_en,
  output logic [ARRAY_SIZE-1:0]        acc_clear,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int                    DRAIN_W    = $clog2(ARRAY_SIZE + 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(ARRAY_SIZE - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [LEN_W-1:0]      LEN_ONE    = LEN_W'(1);
  localparam logic [ARRAY_SIZE-1:0] CLR_FIRST  = ARRAY_SIZE'(1);

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          beat_cnt;
  logic [DRAIN_W-1:0]        drain_cnt;
  logic [ARRAY_SIZE-1:0]     clr_sr;

  logic start_ok;
  logic accept;
  logic last_beat;

  // A zero-length tile is treated as no request at all.
  assign start_ok  = (state_q == S_IDLE) && start && (tile_len != '0);
  assign in_ready  = (state_q == S_FEED) && (beat_cnt < len_q);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat_cnt == (len_q - LEN_ONE));

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign acc_clear = clr_sr;

  always_comb begin
    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_FEED;
      S_FEED:  if (last_beat) state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      clr_sr    <= '0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        len_q    <= tile_len;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + LEN_ONE;
      end

      drain_cnt <= (state_q == S_DRAIN) ? drain_cnt + DRAIN_ONE : '0;

      // One-hot walker: column k clears k cycles after the first, independent of beats.
      clr_sr <= start_ok ? CLR_FIRST : (clr_sr << 1);
    end
  end

  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
    logic              tail_v;
    logic [DATA_W-1:0] tail_d;
    logic              rd_q;
    logic [DATA_W-1:0] ibuf_q;

    if (r == 0) begin : g_direct
      assign tail_v = accept;
      assign tail_d = in_data[0 +: DATA_W];
    end else begin : g_chain
      logic [r-1:0]      v_sr;
      logic [DATA_W-1:0] d_sr [r];

      always_ff @(posedge clk) begin
        // NOTE: the skew data stages are reset too, so an aborted tile leaves nothing stale in flight.
        if (RST) begin
          v_sr <= '0;
          for (int j = 0; j < r; j++) d_sr[j] <= '0;
        end else begin
          v_sr[0] <= accept;
          d_sr[0] <= in_data[r*DATA_W +: DATA_W];
          for (int j = 1; j < r; j++) begin
            v_sr[j] <= v_sr[j-1];
            d_sr[j] <= d_sr[j-1];
          end
        end
      end

      assign tail_v = v_sr[r-1];
      assign tail_d = d_sr[r-1];
    end

    // Output stage: IBUF holds its last value across bubbles.
    always_ff @(posedge clk) begin
      if (RST) begin
        rd_q   <= 1'b0;
        ibuf_q <= '0;
      end else begin
        rd_q <= tail_v;
        if (tail_v) ibuf_q <= tail_d;
      end
    end

    assign input_rd_en[r]               = rd_q;
    assign IBUF[r*DATA_W +: DATA_W]     = ibuf_q;
  end

endmodule

// File: tb/tb_bitfusion_feeder.sv
// Directed bench for bitfusion_feeder: hand-computed per-cycle expectations
// for skew, bubbles, acc_clear, zero-length start, mid-tile reset, back-to-back.
module tb_bitfusion_feeder;

  localparam int AS = 4;
  localparam int DW = 32;
  localparam int LW = 8;

  logic               clk = 1'b0;
  logic               RST;
  logic               start;
  logic [LW-1:0]      tile_len;
  logic               in_valid;
  logic               in_ready;
  logic [AS*DW-1:0]   in_data;
  logic [AS*DW-1:0]   IBUF;
  logic [AS-1:0]      input_rd_en;
  logic [AS-1:0]      acc_clear;
  logic               busy;
  logic               done;

  int n_vec = 0;
  int n_err = 0;

  bitfusion_feeder #(.ARRAY_SIZE(AS), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk         (clk),
    .RST         (RST),
    .start       (start),
    .tile_len    (tile_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .IBUF        (IBUF),
    .input_rd_en (input_rd_en),
    .acc_clear   (acc_clear),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [AS*DW-1:0] beat(input int n);
    return {DW'(32'h30 + n), DW'(32'h20 + n), DW'(32'h10 + n), DW'(n)};
  endfunction

  function automatic logic [AS*DW-1:0] ib4(input logic [7:0] r0, r1, r2, r3);
    return {DW'(r3), DW'(r2), DW'(r1), DW'(r0)};
  endfunction

  localparam logic [AS*DW-1:0] JUNK = {AS{32'hEEEE_EEEE}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AS*DW-1:0] obs, input logic [AS*DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [AS-1:0] rd, input logic rdy, input logic bsy,
                     input logic dn, input logic [AS-1:0] acc, input logic [AS*DW-1:0] ib);
    chk({tag, ".rd_en"},  (AS*DW)'(input_rd_en), (AS*DW)'(rd));
    chk({tag, ".ready"},  (AS*DW)'(in_ready),    (AS*DW)'(rdy));
    chk({tag, ".busy"},   (AS*DW)'(busy),        (AS*DW)'(bsy));
    chk({tag, ".done"},   (AS*DW)'(done),        (AS*DW)'(dn));
    chk({tag, ".clear"},  (AS*DW)'(acc_clear),   (AS*DW)'(acc));
    chk({tag, ".ibuf"},   IBUF,                  ib);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; tile_len = '0; in_valid = 1'b0; in_data = '0;
    step(); step();
    cyc("reset", 4'b0000, 0, 0, 0, 4'b0000, '0);
    RST = 1'b0;
    step();

    // Tile 1: tile_len=3, in_valid held high; a stray start in c3 must be ignored.
    start = 1'b1; tile_len = 8'd3; in_valid = 1'b1; in_data = beat(0);
    step();
    cyc("t1c1", 4'b0000, 1, 1, 0, 4'b0001, ib4(0, 0, 0, 0));
    start = 1'b0;
    step();
    cyc("t1c2", 4'b0001, 1, 1, 0, 4'b0010, ib4(0, 0, 0, 0));
    in_data = beat(1);
    step();
    cyc("t1c3", 4'b0011, 1, 1, 0, 4'b0100, ib4(1, 8'h10, 0, 0));
    in_data = beat(2); start = 1'b1;
    step();
    cyc("t1c4", 4'b0111, 0, 1, 0, 4'b1000, ib4(2, 8'h11, 8'h20, 0));
    start = 1'b0; in_data = JUNK;
    step();
    cyc("t1c5", 4'b1110, 0, 1, 0, 4'b0000, ib4(2, 8'h12, 8'h21, 8'h30));
    step();
    cyc("t1c6", 4'b1100, 0, 1, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h31));
    step();
    cyc("t1c7", 4'b1000, 0, 1, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));
    step();
    cyc("t1c8", 4'b0000, 0, 1, 1, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));
    step();
    cyc("t1c9", 4'b0000, 0, 0, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));

    // Tile 2: same tile with a one-cycle in_valid bubble between beats 1 and 2.
    start = 1'b1; tile_len = 8'd3; in_data = beat(0);
    step();
    cyc("t2c1", 4'b0000, 1, 1, 0, 4'b0001, ib4(2, 8'h12, 8'h22, 8'h32));
    start = 1'b0;
    step();
    cyc("t2c2", 4'b0001, 1, 1, 0, 4'b0010, ib4(0, 8'h12, 8'h22, 8'h32));
    in_data = beat(1);
    step();
    cyc("t2c3", 4'b0011, 1, 1, 0, 4'b0100, ib4(1, 8'h10, 8'h22, 8'h32));
    in_valid = 1'b0; in_data = JUNK;
    step();
    cyc("t2c4", 4'b0110, 1, 1, 0, 4'b1000, ib4(1, 8'h11, 8'h20, 8'h32));
    in_valid = 1'b1; in_data = beat(2);
    step();
    cyc("t2c5", 4'b1101, 0, 1, 0, 4'b0000, ib4(2, 8'h11, 8'h21, 8'h30));
    in_data = JUNK;
    step();
    cyc("t2c6", 4'b1010, 0, 1, 0, 4'b0000, ib4(2, 8'h12, 8'h21, 8'h31));
    step();
    cyc("t2c7", 4'b0100, 0, 1, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h31));
    step();
    cyc("t2c8", 4'b1000, 0, 1, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));
    step();
    cyc("t2c9", 4'b0000, 0, 1, 1, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));
    step();
    cyc("t2c10", 4'b0000, 0, 0, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));

    // Zero-length start is ignored.
    start = 1'b1; tile_len = 8'd0;
    step();
    cyc("t3c1", 4'b0000, 0, 0, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));
    start = 1'b0;
    step();
    cyc("t3c2", 4'b0000, 0, 0, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));
    step();
    cyc("t3c3", 4'b0000, 0, 0, 0, 4'b0000, ib4(2, 8'h12, 8'h22, 8'h32));

    // Reset two cycles after start of a tile_len=5 tile; start during reset loses.
    start = 1'b1; tile_len = 8'd5; in_data = beat(5);
    step();
    cyc("t4c1", 4'b0000, 1, 1, 0, 4'b0001, ib4(2, 8'h12, 8'h22, 8'h32));
    start = 1'b0;
    step();
    cyc("t4c2", 4'b0001, 1, 1, 0, 4'b0010, ib4(5, 8'h12, 8'h22, 8'h32));
    RST = 1'b1; in_data = beat(6);
    step();
    cyc("t4rst", 4'b0000, 0, 0, 0, 4'b0000, '0);
    start = 1'b1; tile_len = 8'd1;
    step();
    cyc("t4rst_start", 4'b0000, 0, 0, 0, 4'b0000, '0);
    RST = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      cyc($sformatf("t4idle%0d", i), 4'b0000, 0, 0, 0, 4'b0000, '0);
    end

    // tile_len=1 after the abort; start held through DONE into the next idle cycle.
    start = 1'b1; tile_len = 8'd1; in_data = beat(7);
    step();
    cyc("t5c1", 4'b0000, 1, 1, 0, 4'b0001, '0);
    start = 1'b0;
    step();
    cyc("t5c2", 4'b0001, 0, 1, 0, 4'b0010, ib4(7, 0, 0, 0));
    in_data = JUNK;
    step();
    cyc("t5c3", 4'b0010, 0, 1, 0, 4'b0100, ib4(7, 8'h17, 0, 0));
    step();
    cyc("t5c4", 4'b0100, 0, 1, 0, 4'b1000, ib4(7, 8'h17, 8'h27, 0));
    step();
    cyc("t5c5", 4'b1000, 0, 1, 0, 4'b0000, ib4(7, 8'h17, 8'h27, 8'h37));
    step();
    cyc("t5c6", 4'b0000, 0, 1, 1, 4'b0000, ib4(7, 8'h17, 8'h27, 8'h37));
    start = 1'b1; tile_len = 8'd2; in_data = beat(8);
    step();
    cyc("t5c7", 4'b0000, 0, 0, 0, 4'b0000, ib4(7, 8'h17, 8'h27, 8'h37));

    // Back-to-back tile_len=2 tile started the cycle after done.
    step();
    cyc("t6c1", 4'b0000, 1, 1, 0, 4'b0001, ib4(7, 8'h17, 8'h27, 8'h37));
    start = 1'b0;
    step();
    cyc("t6c2", 4'b0001, 1, 1, 0, 4'b0010, ib4(8, 8'h17, 8'h27, 8'h37));
    in_data = beat(9);
    step();
    cyc("t6c3", 4'b0011, 0, 1, 0, 4'b0100, ib4(9, 8'h18, 8'h27, 8'h37));
    in_data = JUNK;
    step();
    cyc("t6c4", 4'b0110, 0, 1, 0, 4'b1000, ib4(9, 8'h19, 8'h28, 8'h37));
    step();
    cyc("t6c5", 4'b1100, 0, 1, 0, 4'b0000, ib4(9, 8'h19, 8'h29, 8'h38));
    step();
    cyc("t6c6", 4'b1000, 0, 1, 0, 4'b0000, ib4(9, 8'h19, 8'h29, 8'h39));
    step();
    cyc("t6c7", 4'b0000, 0, 1, 1, 4'b0000, ib4(9, 8'h19, 8'h29, 8'h39));
    step();
    cyc("t6c8", 4'b0000, 0, 0, 0, 4'b0000, ib4(9, 8'h19, 8'h29, 8'h39));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bitfusion_feeder.md
# bitfusion_feeder

Input-side sequencer for the BitFusion systolic array. It accepts one ARRAY_SIZE-wide activation vector per handshake from the upstream activation store and drives the array's IBUF and input_rd_en row ports with the systolic diagonal skew: row i lags row 0 by i cycles. It also pulses the per-column acc_clear at the start of each tile and reports tile completion.

## Interface
Parameters:
- ARRAY_SIZE, 4, rows/columns of the fusion-unit array
- DATA_W, 32, width of one row element
- LEN_W, 8, width of the tile-length field (max tile = 2^LEN_W − 1 beats)

Ports:
- clk  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- start  in  1  begin a tile; sampled only in IDLE
- tile_len  in  LEN_W  beats in the tile; sampled with start
- in_valid  in  1  upstream beat valid
- in_ready  out  1  feeder accepts beat this cycle
- in_data  in  ARRAY_SIZE×DATA_W  element [i] is destined for row i
- IBUF  out  ARRAY_SIZE×DATA_W  per-row input to the array
- input_rd_en  out  ARRAY_SIZE  row i loads IBUF[i] this cycle
- acc_clear  out  ARRAY_SIZE  one-cycle clear for column accumulator k
- busy  out  1  tile in progress
- done  out  1  one-cycle tile-complete pulse

## Operation
- FSM has four states: IDLE, FEED, DRAIN, DONE.
- IDLE → FEED on start=1 with tile_len≠0. At that transition, latch tile_len and clear the beat counter. If start=1 with tile_len=0, the FSM ignores it and stays in IDLE.
- FEED:
  - in_ready = 1 while beat counter < latched tile_len. in_ready is combinational from state and counter.
  - Accept a beat when in_valid & in_ready; the counter increments on each accepted beat.
  - FEED → DRAIN on the edge that accepts beat number tile_len.
- DRAIN: stay for exactly ARRAY_SIZE cycles, counted by a drain counter, then → DONE.
- DONE: lasts one cycle with done=1, then → IDLE.
- Skew path: row i has a shift chain of i stages carrying {valid, data}. Row 0 has no delay stage beyond the output register.
- A cycle with no accepted beat in FEED injects a bubble (valid=0). The bubble propagates down the skew chain identically to a beat.
- input_rd_en[i] = valid bit at the end of the row-i chain.
- IBUF[i] updates only when that valid bit is 1. Otherwise IBUF[i] holds its last value.
- acc_clear[k] pulses once per tile, in cycle S+1+k, where S is the start-acceptance edge. These pulses are generated by a one-hot shift register independent of input beats.
- busy = 1 in FEED, DRAIN and DONE; 0 in IDLE.
- start is ignored whenever busy=1.
- in_data is ignored when in_ready=0.

## Timing
- Reset values: IBUF=0, input_rd_en=0, acc_clear=0, in_ready=0, busy=0, done=0. FSM goes to IDLE and all counters and skew chains clear.
- A beat accepted at edge t appears on IBUF[i] with input_rd_en[i]=1 during cycle t+1+i.
- Tile latency: if the last beat is accepted at edge L, row ARRAY_SIZE−1 presents it in cycle L+ARRAY_SIZE, done=1 in cycle L+ARRAY_SIZE+1, and busy falls after that cycle.
- With in_valid held high, in_ready is high for exactly tile_len consecutive cycles starting the cycle after start.
- The earliest back-to-back start is the cycle after done, because start is accepted only in IDLE.
- Reset asserted mid-tile: on the next edge, all state returns to reset values and in-flight skewed beats are discarded. No done is produced for the aborted tile.
- start asserted in the same cycle as RST: reset wins.

## Test plan
- ARRAY_SIZE=4, tile_len=3, in_valid always 1, in_data beat n = {row3: 0x30+n, row2: 0x20+n, row1: 0x10+n, row0: n}. Required response:
  - IBUF[0] = 0,1,2 in cycles S+2..S+4.
  - IBUF[3] = 0x30,0x31,0x32 in cycles S+5..S+7.
  - done in cycle S+8.
- Same tile with in_valid=0 for one cycle between beats 1 and 2 -> every row shows a one-cycle input_rd_en gap at the same relative position, and done is delayed by exactly 1 cycle.
- start with tile_len=0 -> busy stays 0, and in_ready, input_rd_en and acc_clear stay 0.
- acc_clear check: acc_clear = 0001, 0010, 0100, 1000 in cycles S+1..S+4 and 0 otherwise. A start pulse while busy produces no second pulse train.
- RST high two cycles after start in a tile_len=5 tile -> outputs go to 0 on the next edge and no done is produced. A new start with tile_len=1 then completes with done at its own nominal cycle.
- Back-to-back tiles (start in the cycle after done) -> IBUF values stay continuous with no stale rd_en from the previous tile.
